// File: rtl/decode_operand_latch_pkg.sv
// Shared widths, FSM state and held-entry layout for the decode operand latch.
// Capture bypass / held-entry refresh are enabled by defining DOL_WB_BYPASS_EN.
package decode_operand_latch_pkg;

   localparam int DATA_W = 64;
   localparam int REG_W  = 5;
   localparam int CTRL_W = 8;

   localparam logic [REG_W-1:0] XZR_IDX = 5'd31;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } latchState_e;

   typedef struct packed {
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
      logic [DATA_W-1:0] imm;
      logic [REG_W-1:0]  rs1;
      logic [REG_W-1:0]  rs2;
      logic [REG_W-1:0]  rd;
      logic [CTRL_W-1:0] ctrl;
   } operandEntry_t;

endpackage

// File: rtl/decode_operand_latch_if.sv
// Decode-side, writeback-side and execute-side signals of the operand latch.
// master = surrounding pipeline, slave = the latch itself.
interface decode_operand_latch_if;
   import decode_operand_latch_pkg::*;

   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [REG_W-1:0]  readRegister1;
   logic [REG_W-1:0]  readRegister2;
   logic [DATA_W-1:0] readData1;
   logic [DATA_W-1:0] readData2;
   logic [REG_W-1:0]  writeReg;
   logic [DATA_W-1:0] imm;
   logic [CTRL_W-1:0] ctrl;
   logic              wb_RegWrite;
   logic [REG_W-1:0]  wb_writeReg;
   logic [DATA_W-1:0] wb_writeData;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_op1;
   logic [DATA_W-1:0] out_op2;
   logic [DATA_W-1:0] out_imm;
   logic [REG_W-1:0]  out_rs1;
   logic [REG_W-1:0]  out_rs2;
   logic [REG_W-1:0]  out_rd;
   logic [CTRL_W-1:0] out_ctrl;

   modport master (
      output flush, in_valid, readRegister1, readRegister2, readData1, readData2,
             writeReg, imm, ctrl, wb_RegWrite, wb_writeReg, wb_writeData, out_ready,
      input  in_ready, out_valid, out_op1, out_op2, out_imm, out_rs1, out_rs2,
             out_rd, out_ctrl
   );

   modport slave (
      input  flush, in_valid, readRegister1, readRegister2, readData1, readData2,
             writeReg, imm, ctrl, wb_RegWrite, wb_writeReg, wb_writeData, out_ready,
      output in_ready, out_valid, out_op1, out_op2, out_imm, out_rs1, out_rs2,
             out_rd, out_ctrl
   );

endinterface

// File: rtl/decode_operand_latch_bypass_mux.sv
// Corrects one operand: XZR reads zero, and (with DOL_WB_BYPASS_EN) a matching
// writeback in the same cycle overrides the raw value.
module operand_bypass_mux
   import decode_operand_latch_pkg::*;
(
   input  logic [REG_W-1:0]  regIdx,
   input  logic [DATA_W-1:0] rawData,
   input  logic              wbRegWrite,
   input  logic [REG_W-1:0]  wbWriteReg,
   input  logic [DATA_W-1:0] wbWriteData,
   output logic [DATA_W-1:0] operand
);

   // XZR is checked last so a writeback to register 31 can never leak through.
   always_comb begin
      // NOTE: default assignment first so no path through this block infers a latch.
      operand = rawData;
`ifdef DOL_WB_BYPASS_EN
      if (wbRegWrite && (wbWriteReg == regIdx)) operand = wbWriteData;
`endif
      if (regIdx == XZR_IDX) operand = '0;
   end

`ifdef DOL_WB_BYPASS_EN
`else
   logic unusedWb;
   assign unusedWb = ^{wbRegWrite, wbWriteReg, wbWriteData};
`endif

endmodule

// File: rtl/decode_operand_latch.sv
// Two-entry (head + skid) decode-to-execute operand latch with XZR zeroing and
// optional writeback bypass/refresh (DOL_WB_BYPASS_EN).
module decode_operand_latch
   import decode_operand_latch_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   decode_operand_latch_if.slave  bus
);

   latchState_e   state, stateNext;
   operandEntry_t head, skid, headNext, skidNext;
   operandEntry_t capEntry, headRef, skidRef;
   logic          inReadyQ, outValidQ;
   logic          accept, drain;
   logic [DATA_W-1:0] capOp1, capOp2, headOp1, headOp2, skidOp1, skidOp2;

   assign accept = bus.in_valid & inReadyQ;
   assign drain  = outValidQ & bus.out_ready;

   // Capture-time correction of the register-file read data.
   operand_bypass_mux uCap1 (.regIdx(bus.readRegister1), .rawData(bus.readData1),
      .wbRegWrite(bus.wb_RegWrite), .wbWriteReg(bus.wb_writeReg),
      .wbWriteData(bus.wb_writeData), .operand(capOp1));
   operand_bypass_mux uCap2 (.regIdx(bus.readRegister2), .rawData(bus.readData2),
      .wbRegWrite(bus.wb_RegWrite), .wbWriteReg(bus.wb_writeReg),
      .wbWriteData(bus.wb_writeData), .operand(capOp2));

   // Refresh of held operands against this cycle's writeback.
   operand_bypass_mux uHead1 (.regIdx(head.rs1), .rawData(head.op1),
      .wbRegWrite(bus.wb_RegWrite), .wbWriteReg(bus.wb_writeReg),
      .wbWriteData(bus.wb_writeData), .operand(headOp1));
   operand_bypass_mux uHead2 (.regIdx(head.rs2), .rawData(head.op2),
      .wbRegWrite(bus.wb_RegWrite), .wbWriteReg(bus.wb_writeReg),
      .wbWriteData(bus.wb_writeData), .operand(headOp2));
   operand_bypass_mux uSkid1 (.regIdx(skid.rs1), .rawData(skid.op1),
      .wbRegWrite(bus.wb_RegWrite), .wbWriteReg(bus.wb_writeReg),
      .wbWriteData(bus.wb_writeData), .operand(skidOp1));
   operand_bypass_mux uSkid2 (.regIdx(skid.rs2), .rawData(skid.op2),
      .wbRegWrite(bus.wb_RegWrite), .wbWriteReg(bus.wb_writeReg),
      .wbWriteData(bus.wb_writeData), .operand(skidOp2));

   always_comb begin
      capEntry      = '{op1: capOp1, op2: capOp2, imm: bus.imm,
                        rs1: bus.readRegister1, rs2: bus.readRegister2,
                        rd: bus.writeReg, ctrl: bus.ctrl};
      headRef       = head;
      headRef.op1   = headOp1;
      headRef.op2   = headOp2;
      skidRef       = skid;
      skidRef.op1   = skidOp1;
      skidRef.op2   = skidOp2;
   end

   // State register; in_ready/out_valid are registered copies of the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments only.
         state     <= EMPTY;
         inReadyQ  <= 1'b1;
         outValidQ <= 1'b0;
      end else begin
         state     <= stateNext;
         inReadyQ  <= (stateNext != FULL);
         outValidQ <= (stateNext != EMPTY);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: entry storage is reset too, because the data outputs must read zero.
         head <= '0;
         skid <= '0;
      end else begin
         head <= headNext;
         skid <= skidNext;
      end
   end

   // Next-state logic; flush overrides every transition.
   always_comb begin
      stateNext = state;
      case (state)
         EMPTY:   if (accept) stateNext = ONE;
         ONE: begin
            if (accept && !drain)      stateNext = FULL;
            else if (drain && !accept) stateNext = EMPTY;
         end
         FULL:    if (drain) stateNext = ONE;
         default: stateNext = EMPTY;
      endcase
      if (bus.flush) stateNext = EMPTY;
   end

   // Entry steering: held entries always take their refreshed operands.
   always_comb begin
      headNext = headRef;
      skidNext = skidRef;
      case (state)
         EMPTY: if (accept) headNext = capEntry;
         ONE: begin
            if (accept && drain) headNext = capEntry;
            else if (accept)     skidNext = capEntry;
         end
         FULL:  if (drain) headNext = skidRef;
         default: ;
      endcase
   end

   assign bus.in_ready  = inReadyQ;
   assign bus.out_valid = outValidQ;
   assign bus.out_op1   = head.op1;
   assign bus.out_op2   = head.op2;
   assign bus.out_imm   = head.imm;
   assign bus.out_rs1   = head.rs1;
   assign bus.out_rs2   = head.rs2;
   assign bus.out_rd    = head.rd;
   assign bus.out_ctrl  = head.ctrl;

endmodule

// File: tb/tb_decode_operand_latch.sv
// Self-checking bench for decode_operand_latch: directed steps then random traffic,
// compared against a queue-based model of the latch contents.
module tb_decode_operand_latch;

   logic clk;
   logic rst_n;
   int   passCount  = 0;
   int   checkCount = 0;

   decode_operand_latch_if bus ();

   decode_operand_latch dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] op1, op2, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [7:0]  ctrl;
   } modelEntry_t;

   modelEntry_t q[$];

`ifdef DOL_WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   function automatic logic [63:0] fwd(input logic [4:0] rs, input logic [63:0] raw);
      if (rs == 5'd31) return 64'd0;
      if (BYPASS && bus.wb_RegWrite && bus.wb_writeReg == rs) return bus.wb_writeData;
      return raw;
   endfunction

   task automatic setIn(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic [63:0] d1, input logic [63:0] d2,
                        input logic [63:0] immV, input logic [7:0] ctrlV);
      bus.in_valid      = v;
      bus.readRegister1 = r1;
      bus.readRegister2 = r2;
      bus.writeReg      = rd;
      bus.readData1     = d1;
      bus.readData2     = d2;
      bus.imm           = immV;
      bus.ctrl          = ctrlV;
   endtask

   task automatic setWb(input logic we, input logic [4:0] r, input logic [63:0] d);
      bus.wb_RegWrite  = we;
      bus.wb_writeReg  = r;
      bus.wb_writeData = d;
   endtask

   task automatic compareModel();
      check("out_valid", bus.out_valid, q.size() > 0);
      check("in_ready", bus.in_ready, q.size() < 2);
      if (q.size() > 0) begin
         check("out_op1", bus.out_op1, q[0].op1);
         check("out_op2", bus.out_op2, q[0].op2);
         check("out_imm", bus.out_imm, q[0].imm);
         check("out_rs1", bus.out_rs1, q[0].rs1);
         check("out_rs2", bus.out_rs2, q[0].rs2);
         check("out_rd", bus.out_rd, q[0].rd);
         check("out_ctrl", bus.out_ctrl, q[0].ctrl);
      end
   endtask

   // One clock: update the model from the inputs seen at the edge, then compare.
   task automatic tick();
      bit acc, drn;
      modelEntry_t e;
      @(posedge clk);
      acc = bus.in_valid && (q.size() < 2);
      drn = (q.size() > 0) && bus.out_ready;
      e.op1  = fwd(bus.readRegister1, bus.readData1);
      e.op2  = fwd(bus.readRegister2, bus.readData2);
      e.imm  = bus.imm;
      e.rs1  = bus.readRegister1;
      e.rs2  = bus.readRegister2;
      e.rd   = bus.writeReg;
      e.ctrl = bus.ctrl;
      foreach (q[i]) begin
         q[i].op1 = fwd(q[i].rs1, q[i].op1);
         q[i].op2 = fwd(q[i].rs2, q[i].op2);
      end
      if (drn) void'(q.pop_front());
      if (bus.flush) q.delete();
      else if (acc) q.push_back(e);
      #1;
      compareModel();
   endtask

   function automatic logic [4:0] pickReg();
      case ($urandom_range(0, 3))
         0:       return 5'd31;
         1:       return 5'd12;
         2:       return 5'd7;
         default: return 5'($urandom_range(0, 31));
      endcase
   endfunction

   initial begin
      rst_n         = 1'b1;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      setIn(0, 0, 0, 0, 0, 0, 0, 0);
      setWb(0, 0, 0);
      #1 rst_n = 1'b0;
      #2;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_out_op1", bus.out_op1, 64'd0);
      check("rst_out_op2", bus.out_op2, 64'd0);
      check("rst_out_imm", bus.out_imm, 64'd0);
      check("rst_out_ctrl", bus.out_ctrl, 8'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk) #1;

      // First accept appears one cycle later.
      setIn(1, 3, 4, 1, 64'd10, 64'd20, 64'h55, 8'hA5);
      bus.out_ready = 1'b1;
      tick();
      check("first_op1", bus.out_op1, 64'd10);
      check("first_valid", bus.out_valid, 1'b1);
      check("first_ready", bus.in_ready, 1'b1);
      bus.in_valid = 1'b0;
      tick();

      // XZR reads zero, and a writeback to 31 leaves it alone.
      bus.out_ready = 1'b0;
      setIn(1, 5, 31, 2, 64'd1, 64'hFFFF, 64'd0, 8'h01);
      tick();
      check("xzr_op2", bus.out_op2, 64'd0);
      bus.in_valid = 1'b0;
      setWb(1, 31, 64'd5);
      tick();
      check("xzr_wb_op2", bus.out_op2, 64'd0);
      check("xzr_wb_op1", bus.out_op1, 64'd1);
      setWb(0, 0, 0);
      bus.out_ready = 1'b1;
      tick();

      // Capture-time bypass.
      setIn(1, 12, 2, 3, 64'd23467, 64'd3, 64'd0, 8'h02);
      setWb(1, 12, 64'd99);
      tick();
      check("bypass_op1", bus.out_op1, BYPASS ? 64'd99 : 64'd23467);
      setWb(0, 0, 0);
      bus.in_valid = 1'b0;
      tick();

      // Back-pressure, skid refresh and in-order drain.
      bus.out_ready = 1'b0;
      setIn(1, 1, 2, 4, 64'd11, 64'd12, 64'd0, 8'h10);
      tick();
      check("bp_ready1", bus.in_ready, 1'b1);
      setIn(1, 3, 7, 5, 64'd13, 64'd70, 64'd0, 8'h20);
      tick();
      check("bp_ready2", bus.in_ready, 1'b0);
      setIn(1, 9, 9, 6, 64'd15, 64'd16, 64'd0, 8'h30);
      tick();
      check("bp_head_rd", bus.out_rd, 5'd4);
      bus.in_valid = 1'b0;
      setWb(1, 7, 64'h777);
      tick();
      setWb(0, 0, 0);
      bus.out_ready = 1'b1;
      tick();
      check("skid_rd", bus.out_rd, 5'd5);
      check("skid_op2", bus.out_op2, BYPASS ? 64'h777 : 64'd70);
      tick();
      check("drained", bus.out_valid, 1'b0);

      // Flush while FULL drops the incoming entry.
      bus.out_ready = 1'b0;
      setIn(1, 1, 2, 1, 64'd1, 64'd2, 64'd0, 8'h40);
      tick();
      tick();
      setIn(1, 4, 4, 8, 64'd44, 64'd44, 64'd0, 8'h50);
      bus.flush = 1'b1;
      tick();
      check("flush_valid", bus.out_valid, 1'b0);
      check("flush_ready", bus.in_ready, 1'b1);
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      tick();
      check("flush_gone", bus.out_valid, 1'b0);

      // Asynchronous reset between edges while FULL.
      setIn(1, 1, 2, 1, 64'd5, 64'd6, 64'd7, 8'h60);
      tick();
      tick();
      bus.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      check("arst_valid", bus.out_valid, 1'b0);
      check("arst_ready", bus.in_ready, 1'b1);
      check("arst_op1", bus.out_op1, 64'd0);
      check("arst_imm", bus.out_imm, 64'd0);
      #1 rst_n = 1'b1;
      tick();

      // Random traffic against the model.
      for (int i = 0; i < 500; i++) begin
         setIn(1'($urandom_range(0, 1)), pickReg(), pickReg(), 5'($urandom_range(0, 31)),
               {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
               8'($urandom_range(0, 255)));
         setWb(1'($urandom_range(0, 1)), pickReg(), {$urandom, $urandom});
         bus.out_ready = ($urandom_range(0, 2) != 0);
         bus.flush     = ($urandom_range(0, 19) == 0);
         tick();
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
